// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl
//   Display-mode controller for a multi-channel clock or alarm face.
//   - mode_btn steps through NUM_MODES display channels and wraps back to 0.
//   - segout is a registered copy of the selected channel's {high, low} fields.
//   - While edit_en=1, the field chosen by edit_fld blinks: it shows all-ones
//     for one BLINK_DIV-cycle half-period, then the real value for the next.
//   - A small alarm FSM (IDLE / RINGING / SNOOZE) has bounded ring and snooze
//     timers and drives the buzzer output.
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   mode_btn         pulse: advance to the next display channel
//   hi_bus, lo_bus   packed per-channel fields; channel k is at [k*DW +: DW]
//   edit_en          the current channel is being edited
//   edit_fld         field being edited: 0 = high, 1 = low
//   alarm_en         alarm armed; 0 forces IDLE
//   ring             alarm-match pulse
//   stop_btn         pulse: silence the alarm
//   snooze_btn       pulse: snooze the alarm
//   segout           registered display word {high, low}
//   mode_idx         current channel
//   alarmout         buzzer drive; 1 exactly while in RINGING
//   alarm_st         alarm FSM state code
module disp_mode_ctrl #(
  parameter int NUM_MODES  = 4,
  parameter int DW         = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int RING_CYC   = 60000000,
  parameter int SNOOZE_CYC = 300000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_btn,
  input  logic [NUM_MODES*DW-1:0] hi_bus,
  input  logic [NUM_MODES*DW-1:0] lo_bus,
  input  logic                    edit_en,
  input  logic                    edit_fld,
  input  logic                    alarm_en,
  input  logic                    ring,
  input  logic                    stop_btn,
  input  logic                    snooze_btn,
  output logic [2*DW-1:0]         segout,
  output logic [((NUM_MODES > 2) ? $clog2(NUM_MODES) : 1)-1:0] mode_idx,
  output logic                    alarmout,
  output logic [1:0]              alarm_st
);

  localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int BW = (BLINK_DIV  > 2) ? $clog2(BLINK_DIV)  : 1;
  localparam int RW = (RING_CYC   > 2) ? $clog2(RING_CYC)   : 1;
  localparam int SW = (SNOOZE_CYC > 2) ? $clog2(SNOOZE_CYC) : 1;

  localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_CYC - 1);
  localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RING = 2'b01;
  localparam logic [1:0] ST_SNZ  = 2'b10;

  // ---------------- channel select / display word ----------------
  logic [NUM_MODES-1:0][DW-1:0] hi_arr, lo_arr;
  assign hi_arr = hi_bus;
  assign lo_arr = lo_bus;

  logic [BW-1:0] blk_cnt;
  logic          blink_ph;   // 1 = visible half-period
  logic          fld_q;      // edit_fld from the previous edge, used to detect a change
  logic          blank;
  logic [DW-1:0] hi_sel, lo_sel;

  assign hi_sel = hi_arr[mode_idx];
  assign lo_sel = lo_arr[mode_idx];
  assign blank  = edit_en && !blink_ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_idx <= '0;
      segout   <= '0;
    end else begin
      if (mode_btn) mode_idx <= (mode_idx == MODE_LAST) ? '0 : mode_idx + MW'(1);
      // This uses the pre-update mode_idx, so a channel change reaches segout
      // on the second edge after the button press.
      segout <= {(blank && !edit_fld) ? {DW{1'b1}} : hi_sel,
                 (blank &&  edit_fld) ? {DW{1'b1}} : lo_sel};
    end
  end

  // Blink phase restarts visible whenever editing stops, the channel changes,
  // or the edited field changes, so the user always sees the value first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt  <= '0;
      blink_ph <= 1'b1;
      fld_q    <= 1'b0;
    end else begin
      fld_q <= edit_fld;
      if (!edit_en || mode_btn || (edit_fld != fld_q)) begin
        blk_cnt  <= '0;
        blink_ph <= 1'b1;
      end else if (blk_cnt == BLINK_LAST) begin
        blk_cnt  <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        blk_cnt <= blk_cnt + BW'(1);
      end
    end
  end

  // ---------------- alarm FSM ----------------
  logic [1:0]    st_nxt;
  logic [RW-1:0] rtmr, rt_nxt;
  logic [SW-1:0] stmr, sn_nxt;

  // Each timer stops at its last value by leaving its state, so it never wraps.
  always_comb begin
    st_nxt = alarm_st;
    rt_nxt = rtmr;
    sn_nxt = stmr;
    if (!alarm_en) begin
      st_nxt = ST_IDLE;
    end else begin
      case (alarm_st)
        ST_IDLE: if (ring) begin
          st_nxt = ST_RING;
          rt_nxt = '0;
        end
        ST_RING: begin
          if (stop_btn)              st_nxt = ST_IDLE;
          else if (snooze_btn) begin st_nxt = ST_SNZ; sn_nxt = '0; end
          else if (rtmr == RING_LAST) st_nxt = ST_IDLE;
          else                       rt_nxt = rtmr + RW'(1);
        end
        ST_SNZ: begin
          if (stop_btn)              st_nxt = ST_IDLE;
          else if (stmr == SNZ_LAST) begin st_nxt = ST_RING; rt_nxt = '0; end
          else                       sn_nxt = stmr + SW'(1);
        end
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_st <= ST_IDLE;
      rtmr     <= '0;
      stmr     <= '0;
      alarmout <= 1'b0;
    end else begin
      alarm_st <= st_nxt;
      rtmr     <= rt_nxt;
      stmr     <= sn_nxt;
      alarmout <= (st_nxt == ST_RING);
    end
  end

endmodule

// File: tb/tb_disp_mode_ctrl.sv
module tb_disp_mode_ctrl;
  localparam int NM = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode_btn, edit_en, edit_fld, alarm_en, ring, stop_btn, snooze_btn;
  logic [NM*DW-1:0] hi_bus, lo_bus;
  logic [2*DW-1:0] segout;
  logic [1:0]      mode_idx;
  logic            alarmout;
  logic [1:0]      alarm_st;

  int n_cmp = 0;
  int n_err = 0;

  disp_mode_ctrl #(.NUM_MODES(NM), .DW(DW), .BLINK_DIV(4), .RING_CYC(10), .SNOOZE_CYC(5)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .hi_bus(hi_bus), .lo_bus(lo_bus),
    .edit_en(edit_en), .edit_fld(edit_fld), .alarm_en(alarm_en), .ring(ring),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn), .segout(segout), .mode_idx(mode_idx),
    .alarmout(alarmout), .alarm_st(alarm_st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the edge, then sample 1 time unit later. Inputs also change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_btn = 1'b1; tick(); mode_btn = 1'b0;
  endtask

  task automatic start_ring();
    ring = 1'b1; tick(); ring = 1'b0;
  endtask

  // Expected blink pattern for segout[7:0] after edges 1..13 when edit starts.
  // The first edge clears the counter while the value is still visible.
  logic [7:0] exp_lo [13] = '{8'h45, 8'h45, 8'h45, 8'h45, 8'h45,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF,
                              8'h45, 8'h45, 8'h45, 8'h45};

  initial begin
    int n;
    rst = 1'b1;
    mode_btn = 0; edit_en = 0; edit_fld = 0; alarm_en = 0; ring = 0; stop_btn = 0; snooze_btn = 0;
    hi_bus = 24'h122334;   // ch0=34 ch1=23 ch2=12
    lo_bus = 24'hA1B2C3;   // ch0=C3 ch1=B2 ch2=A1
    #1;
    chk("rst_mode", mode_idx, 0);
    chk("rst_seg", segout, 0);
    chk("rst_alarm", alarmout, 0);
    chk("rst_st", alarm_st, 0);
    tick(); tick();
    rst = 1'b0;

    // Channel stepping and wrap
    tick();
    chk("seg_m0", segout, 16'h34C3);
    pulse_mode();
    chk("mode1", mode_idx, 1);
    chk("seg_lag", segout, 16'h34C3);
    tick();
    chk("seg_m1", segout, 16'h23B2);
    pulse_mode();
    chk("mode2", mode_idx, 2);
    tick();
    chk("seg_m2", segout, 16'h12A1);
    pulse_mode();
    chk("mode_wrap", mode_idx, 0);
    tick();
    chk("seg_hi_m0", segout[15:8], 8'h34);

    // Blinking the low field
    lo_bus = 24'hA1B245;
    edit_en = 1'b1; edit_fld = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("blink_%0d", k + 1), segout, {8'h34, exp_lo[k]});
    end
    edit_en = 1'b0; edit_fld = 1'b0;
    tick(); tick();
    chk("blink_off", segout, 16'h3445);

    // Ring timeout
    alarm_en = 1'b1;
    start_ring();
    chk("ring_st", alarm_st, 2'b01);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!alarmout) break;
      n++;
    end
    chk("ring_len", n, 10);
    chk("ring_end_st", alarm_st, 2'b00);

    // Snooze on the third ringing cycle
    start_ring();
    tick(); tick();
    snooze_btn = 1'b1; tick(); snooze_btn = 1'b0;
    chk("snz_st", alarm_st, 2'b10);
    chk("snz_out", alarmout, 0);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (alarmout) break;
      n++;
    end
    chk("snz_len", n, 5);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!alarmout) break;
      n++;
    end
    chk("re_ring_len", n, 10);
    chk("re_ring_end", alarm_st, 2'b00);

    // Ring is ignored while already ringing: the timer keeps running
    start_ring();
    tick(); tick();
    ring = 1'b1; tick(); ring = 1'b0;
    n = 4;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!alarmout) break;
      n++;
    end
    chk("ring_ignored", n, 10);

    // Stop wins over snooze
    start_ring();
    stop_btn = 1'b1; snooze_btn = 1'b1; tick(); stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("prio_st", alarm_st, 2'b00);
    chk("prio_out", alarmout, 0);

    // alarm_en=0 during snooze
    start_ring();
    snooze_btn = 1'b1; tick(); snooze_btn = 1'b0;
    chk("en_snz_st", alarm_st, 2'b10);
    alarm_en = 1'b0; tick();
    chk("en_off_st", alarm_st, 2'b00);
    for (int k = 0; k < 8; k++) tick();
    chk("en_off_hold", alarm_st, 2'b00);
    alarm_en = 1'b1;

    // Asynchronous reset while ringing, between edges
    start_ring();
    chk("pre_rst_out", alarmout, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", alarmout, 0);
    chk("arst_st", alarm_st, 2'b00);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (alarmout) n++;
    end
    chk("no_resume", n, 0);

    // Asynchronous reset of the channel index
    pulse_mode(); pulse_mode();
    chk("pre_rst_mode", mode_idx, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", mode_idx, 0);
    chk("arst_seg", segout, 0);
    rst = 1'b0;
    pulse_mode();
    chk("first_edge", mode_idx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
